// File: rtl/object_locator.sv
// ---------------------------------------------------------------------------
// object_locator
//
// Computes the centroid of all pixels flagged as belonging to the tracked
// object over one video frame.  Coordinate sums and a hit count are
// accumulated per frame.  At end of frame the totals are snapshotted and two
// restoring dividers (x and y, in parallel) run during blanking, one quotient
// bit per cycle.  The last valid centre is held between updates.
//
// Ports:
//   clk          in   system clock
//   aresetn      in   asynchronous active-low reset
//   enable       in   pixel strobe, inputs sampled only when high
//   is_target    in   current pixel belongs to the object
//   x_pos        in   current pixel x  [DISP_WIDTH]
//   y_pos        in   current pixel y  [DISP_WIDTH]
//   end_of_frame in   one-cycle pulse after the last pixel of a frame
//   x_obj        out  centroid x, registered  [DISP_WIDTH]
//   y_obj        out  centroid y, registered  [DISP_WIDTH]
//   obj_found    out  last completed frame had at least MIN_PIXELS hits
//   pos_update   out  one-cycle pulse when the outputs refresh
//   busy         out  divider running
// ---------------------------------------------------------------------------
module object_locator #(
    parameter int DISP_WIDTH = 11,
    parameter int MIN_PIXELS = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic                  is_target,
    input  logic [DISP_WIDTH-1:0] x_pos,
    input  logic [DISP_WIDTH-1:0] y_pos,
    input  logic                  end_of_frame,
    output logic [DISP_WIDTH-1:0] x_obj,
    output logic [DISP_WIDTH-1:0] y_obj,
    output logic                  obj_found,
    output logic                  pos_update,
    output logic                  busy
);

    localparam int CNT_WIDTH  = 2 * DISP_WIDTH;
    localparam int SUM_WIDTH  = 3 * DISP_WIDTH;
    localparam int ITER_WIDTH = $clog2(SUM_WIDTH + 1);

    localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(SUM_WIDTH - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_ONE  = ITER_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  MIN_CNT   = CNT_WIDTH'(MIN_PIXELS);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, subtract the divisor when it fits, and shift the
    // resulting quotient bit into the low end of the dividend register.
    // Returns {new_remainder, new_quotient_register}.
    function automatic logic [CNT_WIDTH+SUM_WIDTH-1:0] div_step(
        input logic [CNT_WIDTH-1:0] rem,
        input logic [SUM_WIDTH-1:0] quo,
        input logic [CNT_WIDTH-1:0] dvsr
    );
        logic [CNT_WIDTH:0]   trial;
        logic [CNT_WIDTH-1:0] diff;
        trial = {rem, quo[SUM_WIDTH-1]};
        // The difference is smaller than the divisor, so its low bits suffice.
        diff  = trial[CNT_WIDTH-1:0] - dvsr;
        if (trial >= {1'b0, dvsr}) begin
            return {diff, quo[SUM_WIDTH-2:0], 1'b1};
        end else begin
            return {trial[CNT_WIDTH-1:0], quo[SUM_WIDTH-2:0], 1'b0};
        end
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;

    logic                    hit_s;
    logic [SUM_WIDTH-1:0]    x_inc_s;
    logic [SUM_WIDTH-1:0]    y_inc_s;
    logic [CNT_WIDTH-1:0]    cnt_inc_s;
    logic [SUM_WIDTH-1:0]    sum_x_tot_s;
    logic [SUM_WIDTH-1:0]    sum_y_tot_s;
    logic [CNT_WIDTH-1:0]    count_tot_s;

    logic [SUM_WIDTH-1:0]    sum_x_r;
    logic [SUM_WIDTH-1:0]    sum_y_r;
    logic [CNT_WIDTH-1:0]    count_r;

    logic [CNT_WIDTH-1:0]    rem_x_r;
    logic [CNT_WIDTH-1:0]    rem_y_r;
    logic [SUM_WIDTH-1:0]    quo_x_r;
    logic [SUM_WIDTH-1:0]    quo_y_r;
    logic [CNT_WIDTH-1:0]    dvsr_r;
    logic [ITER_WIDTH-1:0]   iter_r;

    logic [CNT_WIDTH+SUM_WIDTH-1:0] step_x_s;
    logic [CNT_WIDTH+SUM_WIDTH-1:0] step_y_s;

    logic [DISP_WIDTH-1:0]   x_obj_r;
    logic [DISP_WIDTH-1:0]   y_obj_r;
    logic                    obj_found_r;
    logic                    pos_update_r;
    logic                    busy_r;

    // Running totals including the current pixel, so a hit on the
    // end_of_frame cycle still lands in the frame that is ending.
    always_comb begin
        hit_s       = enable & is_target;
        x_inc_s     = {SUM_WIDTH{1'b0}};
        y_inc_s     = {SUM_WIDTH{1'b0}};
        cnt_inc_s   = {CNT_WIDTH{1'b0}};
        if (hit_s) begin
            x_inc_s   = SUM_WIDTH'(x_pos);
            y_inc_s   = SUM_WIDTH'(y_pos);
            cnt_inc_s = CNT_ONE;
        end else begin
            x_inc_s   = {SUM_WIDTH{1'b0}};
            y_inc_s   = {SUM_WIDTH{1'b0}};
            cnt_inc_s = {CNT_WIDTH{1'b0}};
        end
        sum_x_tot_s = sum_x_r + x_inc_s;
        sum_y_tot_s = sum_y_r + y_inc_s;
        count_tot_s = count_r + cnt_inc_s;
    end

    // Frame accumulators: run in every state, cleared on every end_of_frame
    // (whether or not the totals are taken by the divider).
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sum_x_r <= {SUM_WIDTH{1'b0}};
            sum_y_r <= {SUM_WIDTH{1'b0}};
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (end_of_frame) begin
            sum_x_r <= {SUM_WIDTH{1'b0}};
            sum_y_r <= {SUM_WIDTH{1'b0}};
            count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            sum_x_r <= sum_x_tot_s;
            sum_y_r <= sum_y_tot_s;
            count_r <= count_tot_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; end_of_frame is only acted upon in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (end_of_frame) begin
                    state_next_s = ST_DIVIDE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (iter_r == LAST_ITER) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DIVIDE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next divider step for both axes.
    always_comb begin
        step_x_s = div_step(rem_x_r, quo_x_r, dvsr_r);
        step_y_s = div_step(rem_y_r, quo_y_r, dvsr_r);
    end

    // Divider datapath: snapshot on an accepted end_of_frame, then one
    // quotient bit per DIVIDE cycle.  A zero divisor just yields garbage that
    // the output stage discards because the count is below the threshold.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rem_x_r <= {CNT_WIDTH{1'b0}};
            rem_y_r <= {CNT_WIDTH{1'b0}};
            quo_x_r <= {SUM_WIDTH{1'b0}};
            quo_y_r <= {SUM_WIDTH{1'b0}};
            dvsr_r  <= {CNT_WIDTH{1'b0}};
            iter_r  <= {ITER_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (end_of_frame) begin
                        rem_x_r <= {CNT_WIDTH{1'b0}};
                        rem_y_r <= {CNT_WIDTH{1'b0}};
                        quo_x_r <= sum_x_tot_s;
                        quo_y_r <= sum_y_tot_s;
                        dvsr_r  <= count_tot_s;
                        iter_r  <= {ITER_WIDTH{1'b0}};
                    end
                end
                ST_DIVIDE: begin
                    {rem_x_r, quo_x_r} <= step_x_s;
                    {rem_y_r, quo_y_r} <= step_y_s;
                    iter_r             <= iter_r + ITER_ONE;
                end
                default: begin
                    iter_r <= iter_r;
                end
            endcase
        end
    end

    // Output stage: refresh in DONE only; positions are held when the frame
    // did not contain enough hits.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x_obj_r      <= {DISP_WIDTH{1'b0}};
            y_obj_r      <= {DISP_WIDTH{1'b0}};
            obj_found_r  <= 1'b0;
            pos_update_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            pos_update_r <= (state_r == ST_DONE);
            busy_r       <= (state_next_s != ST_IDLE);
            if (state_r == ST_DONE) begin
                if (dvsr_r >= MIN_CNT) begin
                    // Mean is below 2^DISP_WIDTH, so the low bits are exact.
                    x_obj_r     <= quo_x_r[DISP_WIDTH-1:0];
                    y_obj_r     <= quo_y_r[DISP_WIDTH-1:0];
                    obj_found_r <= 1'b1;
                end else begin
                    obj_found_r <= 1'b0;
                end
            end
        end
    end

    assign x_obj      = x_obj_r;
    assign y_obj      = y_obj_r;
    assign obj_found  = obj_found_r;
    assign pos_update = pos_update_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_object_locator.sv
module tb_object_locator;

    localparam int DW  = 11;
    localparam int SW  = 3 * DW;
    localparam int LAT = SW + 1;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          enable;
    logic          is_target;
    logic [DW-1:0] x_pos;
    logic [DW-1:0] y_pos;
    logic          end_of_frame;

    logic [DW-1:0] x_a, y_a, x_b, y_b;
    logic          found_a, upd_a, busy_a;
    logic          found_b, upd_b, busy_b;

    always #5 clk = ~clk;

    // Instance A: default threshold (16). Instance B: threshold 1.
    object_locator #(.DISP_WIDTH(DW), .MIN_PIXELS(16)) dut_a (
        .clk(clk), .aresetn(aresetn), .enable(enable), .is_target(is_target),
        .x_pos(x_pos), .y_pos(y_pos), .end_of_frame(end_of_frame),
        .x_obj(x_a), .y_obj(y_a), .obj_found(found_a),
        .pos_update(upd_a), .busy(busy_a)
    );

    object_locator #(.DISP_WIDTH(DW), .MIN_PIXELS(1)) dut_b (
        .clk(clk), .aresetn(aresetn), .enable(enable), .is_target(is_target),
        .x_pos(x_pos), .y_pos(y_pos), .end_of_frame(end_of_frame),
        .x_obj(x_b), .y_obj(y_b), .obj_found(found_b),
        .pos_update(upd_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int upd_cnt_a = 0;
    int stab_err  = 0;

    // Reference model state
    longint m_sx, m_sy, m_cnt;
    bit     m_busy;
    int     eof_cyc;
    longint ex_a, ey_a, ex_b, ey_b;
    bit     ef_a, ef_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counter and output-stability watcher
    logic [DW-1:0] px_a, py_a, px_b, py_b;
    logic          pf_a, pf_b, pv;
    initial pv = 1'b0;
    always @(negedge clk) begin
        if (upd_a) upd_cnt_a <= upd_cnt_a + 1;
        if (aresetn && pv && !upd_a && (x_a != px_a || y_a != py_a || found_a != pf_a))
            stab_err <= stab_err + 1;
        if (aresetn && pv && !upd_b && (x_b != px_b || y_b != py_b || found_b != pf_b))
            stab_err <= stab_err + 1;
        px_a <= x_a; py_a <= y_a; pf_a <= found_a;
        px_b <= x_b; py_b <= y_b; pf_b <= found_b;
        pv   <= aresetn;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_cnt = 0; m_busy = 1'b0;
        ex_a = 0; ey_a = 0; ef_a = 1'b0;
        ex_b = 0; ey_b = 0; ef_b = 1'b0;
    endtask

    // Frame end: a frame is measured only if no division is outstanding.
    task automatic model_eof();
        if (!m_busy) begin
            m_busy  = 1'b1;
            eof_cyc = cyc;
            if (m_cnt >= 16) begin
                ex_a = m_sx / m_cnt; ey_a = m_sy / m_cnt; ef_a = 1'b1;
            end else begin
                ef_a = 1'b0;
            end
            if (m_cnt >= 1) begin
                ex_b = m_sx / m_cnt; ey_b = m_sy / m_cnt; ef_b = 1'b1;
            end else begin
                ef_b = 1'b0;
            end
        end
        m_sx = 0; m_sy = 0; m_cnt = 0;
    endtask

    task automatic step(input bit en, input bit tgt, input int x, input int y, input bit eof);
        enable = en; is_target = tgt; x_pos = x[DW-1:0]; y_pos = y[DW-1:0];
        end_of_frame = eof;
        @(posedge clk); #1;
        if (en && tgt) begin m_sx += x; m_sy += y; m_cnt++; end
        if (eof) model_eof();
        enable = 1'b0; is_target = 1'b0; end_of_frame = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic block(input int x0, input int y0, input int w, input int h);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                step(1'b1, 1'b1, x0 + i, y0 + j, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic wait_check(input string nm);
        int n;
        bit got;
        n = 0; got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (upd_a) got = 1'b1;
        end
        chk({nm, "_update_seen"}, longint'(got), 1);
        if (got) begin
            chk({nm, "_latency"}, cyc - eof_cyc, LAT);
            chk({nm, "_upd_b"}, upd_b, 1);
            chk({nm, "_busy"}, busy_a, 0);
            chk({nm, "_x_a"}, x_a, ex_a);
            chk({nm, "_y_a"}, y_a, ey_a);
            chk({nm, "_found_a"}, found_a, ef_a);
            chk({nm, "_x_b"}, x_b, ex_b);
            chk({nm, "_y_b"}, y_b, ey_b);
            chk({nm, "_found_b"}, found_b, ef_b);
        end
        m_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_x_a"}, x_a, 0);
        chk({nm, "_y_a"}, y_a, 0);
        chk({nm, "_found_a"}, found_a, 0);
        chk({nm, "_upd_a"}, upd_a, 0);
        chk({nm, "_busy_a"}, busy_a, 0);
        chk({nm, "_x_b"}, x_b, 0);
        chk({nm, "_busy_b"}, busy_b, 0);
    endtask

    typedef struct {
        int x0, y0, w, h;
        int ex, ey;
        bit ef;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int u0;
        // Block origin/size and expected outputs of the threshold-16 instance
        tbl[0] = '{x0: 100,  y0: 50,   w: 4, h: 4, ex: 101,  ey: 51,   ef: 1'b1};
        tbl[1] = '{x0: 10,   y0: 7,    w: 5, h: 1, ex: 101,  ey: 51,   ef: 1'b0};
        tbl[2] = '{x0: 200,  y0: 300,  w: 8, h: 2, ex: 203,  ey: 300,  ef: 1'b1};
        tbl[3] = '{x0: 2040, y0: 2040, w: 8, h: 8, ex: 2043, ey: 2043, ef: 1'b1};
        tbl[4] = '{x0: 0,    y0: 0,    w: 1, h: 1, ex: 2043, ey: 2043, ef: 1'b0};

        aresetn = 1'b0; enable = 1'b0; is_target = 1'b0;
        x_pos = '0; y_pos = '0; end_of_frame = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;

        // Reset asserted in the middle of a pixel stream
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 20 + i, 30, 1'b0);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("rst_stream");
        model_clear();
        @(posedge clk); #1 aresetn = 1'b1;

        // Empty frame
        step(1'b0, 1'b0, 0, 0, 1'b1);
        wait_check("empty");

        // Table of rectangular blocks
        for (int i = 0; i < 5; i++) begin
            block(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h);
            wait_check($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_x", i), x_a, tbl[i].ex);
            chk($sformatf("tbl%0d_y", i), y_a, tbl[i].ey);
            chk($sformatf("tbl%0d_found", i), found_a, tbl[i].ef);
        end

        // Disabled hits ignored; a hit on the end_of_frame cycle counts
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0, 0, 1'b0);
        step(1'b1, 1'b1, 2047, 2047, 1'b1);
        wait_check("corner");
        chk("corner_x_b", x_b, 2047);
        chk("corner_y_b", y_b, 2047);

        // Second end_of_frame during DIVIDE is discarded
        block(500, 600, 4, 4);
        u0 = upd_cnt_a;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b1);
        wait_check("dbl");
        chk("dbl_x", x_a, 501);
        idle(45);
        chk("dbl_pulses", upd_cnt_a - u0, 1);
        block(1000, 1000, 4, 4);
        wait_check("third");
        chk("third_x", x_a, 1001);

        // Reset during DIVIDE
        block(300, 400, 4, 4);
        u0 = upd_cnt_a;
        idle(19);
        chk("rst_div_busy_before", busy_a, 1);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("rst_div");
        model_clear();
        @(posedge clk); #1 aresetn = 1'b1;
        idle(45);
        chk("rst_div_no_pulse", upd_cnt_a - u0, 0);
        chk("rst_div_x_after", x_a, 0);
        block(300, 400, 4, 4);
        wait_check("after_rst");
        chk("after_rst_x", x_a, 301);
        chk("after_rst_y", y_a, 401);

        // Randomized frames against the model
        for (int f = 0; f < 8; f++) begin
            int n;
            n = int'($urandom_range(0, 40));
            for (int k = 0; k < n; k++)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                     int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b0);
            step($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                 int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b1);
            wait_check($sformatf("rnd%0d", f));
            idle(int'($urandom_range(0, 5)));
        end

        chk("output_stability", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
